muldiv_issue: RTL and testbench



---
 rtl/eei.sv | 26 ++
 rtl/muldiv_reuse_cache.sv | 54 +++++
 rtl/muldiv_issue.sv | 152 +++++++++++++++
 tb/tb_muldiv_issue.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eei.sv
// Shared execution-environment definitions for the mul/div issue front end:
// operand width, M-extension funct3 encodings and the issue FSM state type.
package eei;

    localparam int unsigned XLEN = 64;

    typedef logic [XLEN-1:0] UIntX;

    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;
    localparam logic [2:0] DIV    = 3'b100;
    localparam logic [2:0] DIVU   = 3'b101;
    localparam logic [2:0] REM    = 3'b110;
    localparam logic [2:0] REMU   = 3'b111;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } md_state_t;

endpackage

// File: rtl/muldiv_reuse_cache.sv
// Single-entry last-result store for the mul/div issue front end.
// Only built when MULDIV_REUSE_EN is defined; the default build has no cache.
`ifdef MULDIV_REUSE_EN
module muldiv_reuse_cache #(
    parameter int unsigned XLEN = eei::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [2:0]      wr_funct3,
    input  logic            wr_is_op32,
    input  logic [XLEN-1:0] wr_op1,
    input  logic [XLEN-1:0] wr_op2,
    input  logic [XLEN-1:0] wr_result,
    input  logic [2:0]      lk_funct3,
    input  logic            lk_is_op32,
    input  logic [XLEN-1:0] lk_op1,
    input  logic [XLEN-1:0] lk_op2,
    output logic            hit,
    output logic [XLEN-1:0] hit_result
);

    logic            vld;
    logic [2:0]      funct3_q;
    logic            is_op32_q;
    logic [XLEN-1:0] op1_q;
    logic [XLEN-1:0] op2_q;
    logic [XLEN-1:0] result_q;

    // Entry is overwritten by every completed result; only reset invalidates it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld       <= 1'b0;
            funct3_q  <= '0;
            is_op32_q <= 1'b0;
            op1_q     <= '0;
            op2_q     <= '0;
            result_q  <= '0;
        end else if (wr_en) begin
            vld       <= 1'b1;
            funct3_q  <= wr_funct3;
            is_op32_q <= wr_is_op32;
            op1_q     <= wr_op1;
            op2_q     <= wr_op2;
            result_q  <= wr_result;
        end
    end

    assign hit = vld && (lk_funct3 == funct3_q) && (lk_is_op32 == is_op32_q) &&
                 (lk_op1 == op1_q) && (lk_op2 == op2_q);
    assign hit_result = result_q;

endmodule
`endif

// File: rtl/muldiv_issue.sv
// Execute-stage front end for the iterative mul/div unit: captures one
// M-extension op, issues it over valid/ready, waits for the rvalid pulse and
// presents a one-cycle writeback beat. Flush while busy drains the unit.
// Optional feature macro: MULDIV_REUSE_EN (last-result reuse cache).
module muldiv_issue #(
    parameter int unsigned XLEN     = eei::XLEN,
    parameter int unsigned RD_WIDTH = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ex_valid,
    input  logic                ex_is_muldiv,
    input  logic [2:0]          ex_funct3,
    input  logic                ex_is_op32,
    input  logic [XLEN-1:0]     ex_op1,
    input  logic [XLEN-1:0]     ex_op2,
    input  logic [RD_WIDTH-1:0] ex_rd,
    input  logic                flush,
    output logic                stall,
    output logic                md_valid,
    input  logic                md_ready,
    output logic [2:0]          md_funct3,
    output logic                md_is_op32,
    output logic [XLEN-1:0]     md_op1,
    output logic [XLEN-1:0]     md_op2,
    input  logic                md_rvalid,
    input  logic [XLEN-1:0]     md_result,
    output logic                wb_valid,
    output logic [RD_WIDTH-1:0] wb_rd,
    output logic [XLEN-1:0]     wb_data
);
    import eei::*;

    md_state_t           state;
    logic                req;
    logic [2:0]          funct3_q;
    logic                is_op32_q;
    logic [XLEN-1:0]     op1_q;
    logic [XLEN-1:0]     op2_q;
    logic [RD_WIDTH-1:0] rd_q;
    logic [RD_WIDTH-1:0] wb_rd_q;
    logic [XLEN-1:0]     result_q;
    logic                hit;
    logic [XLEN-1:0]     hit_result;

    assign req   = ex_valid && ex_is_muldiv && !flush;
    assign stall = req && (state != DONE);

    assign md_valid   = (state == ISSUE) && !flush;
    assign md_funct3  = funct3_q;
    assign md_is_op32 = is_op32_q;
    assign md_op1     = op1_q;
    assign md_op2     = op2_q;

    assign wb_valid = (state == DONE) && !flush;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = result_q;

`ifdef MULDIV_REUSE_EN
    logic cache_wr;

    assign cache_wr = (state == WAIT) && md_rvalid && !flush;

    muldiv_reuse_cache #(
        .XLEN (XLEN)
    ) u_cache (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (cache_wr),
        .wr_funct3  (funct3_q),
        .wr_is_op32 (is_op32_q),
        .wr_op1     (op1_q),
        .wr_op2     (op2_q),
        .wr_result  (md_result),
        .lk_funct3  (ex_funct3),
        .lk_is_op32 (ex_is_op32),
        .lk_op1     (ex_op1),
        .lk_op2     (ex_op2),
        .hit        (hit),
        .hit_result (hit_result)
    );
`else
    assign hit        = 1'b0;
    assign hit_result = '0;
`endif

    // Issue FSM plus capture/result registers. wb_rd has its own register,
    // loaded only on entry to DONE, so it holds while the next op is captured.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            funct3_q  <= '0;
            is_op32_q <= 1'b0;
            op1_q     <= '0;
            op2_q     <= '0;
            rd_q      <= '0;
            wb_rd_q   <= '0;
            result_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        funct3_q  <= ex_funct3;
                        is_op32_q <= ex_is_op32;
                        op1_q     <= ex_op1;
                        op2_q     <= ex_op2;
                        rd_q      <= ex_rd;
                        if (hit) begin
                            wb_rd_q  <= ex_rd;
                            result_q <= hit_result;
                            state    <= DONE;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (flush) begin
                        state <= IDLE;
                    end else if (md_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (md_rvalid) begin
                        if (!flush) begin
                            result_q <= md_result;
                            wb_rd_q  <= rd_q;
                            state    <= DONE;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (flush) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (md_rvalid) begin
                        state <= IDLE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_issue.sv
// Self-checking bench for muldiv_issue with a behavioural mul/div unit.
// Expected writebacks go into a scoreboard queue and are popped on wb_valid.
module tb_muldiv_issue;
    import eei::*;

    localparam int unsigned XL = 64;
    localparam int unsigned RW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ex_valid = 1'b0;
    logic          ex_is_muldiv = 1'b0;
    logic [2:0]    ex_funct3 = '0;
    logic          ex_is_op32 = 1'b0;
    logic [XL-1:0] ex_op1 = '0;
    logic [XL-1:0] ex_op2 = '0;
    logic [RW-1:0] ex_rd = '0;
    logic          flush = 1'b0;
    logic          stall;
    logic          md_valid;
    logic          md_ready;
    logic [2:0]    md_funct3;
    logic          md_is_op32;
    logic [XL-1:0] md_op1;
    logic [XL-1:0] md_op2;
    logic          md_rvalid;
    logic [XL-1:0] md_result;
    logic          wb_valid;
    logic [RW-1:0] wb_rd;
    logic [XL-1:0] wb_data;

    muldiv_issue #(
        .XLEN     (XL),
        .RD_WIDTH (RW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .ex_is_muldiv (ex_is_muldiv),
        .ex_funct3    (ex_funct3),
        .ex_is_op32   (ex_is_op32),
        .ex_op1       (ex_op1),
        .ex_op2       (ex_op2),
        .ex_rd        (ex_rd),
        .flush        (flush),
        .stall        (stall),
        .md_valid     (md_valid),
        .md_ready     (md_ready),
        .md_funct3    (md_funct3),
        .md_is_op32   (md_is_op32),
        .md_op1       (md_op1),
        .md_op2       (md_op2),
        .md_rvalid    (md_rvalid),
        .md_result    (md_result),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [RW-1:0] rd;
        logic [XL-1:0] data;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned n_checks   = 0;
    int unsigned n_fail     = 0;
    int unsigned n_pushed   = 0;
    int unsigned n_beats    = 0;
    int unsigned hs_count   = 0;
    int unsigned drain_seen = 0;
    int unsigned inv_viol   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference M-extension arithmetic (RV64, W-forms sign-extend the low word).
    function automatic logic [63:0] ref_md(input logic [2:0] f, input logic w,
                                           input logic [63:0] a, input logic [63:0] b);
        logic [63:0]  x;
        logic [63:0]  y;
        logic [63:0]  r;
        logic [127:0] p;
        x = a;
        y = b;
        r = '0;
        p = '0;
        if (w) begin
            if (f == DIVU || f == REMU) begin
                x = {32'b0, a[31:0]};
                y = {32'b0, b[31:0]};
            end else begin
                x = {{32{a[31]}}, a[31:0]};
                y = {{32{b[31]}}, b[31:0]};
            end
        end
        case (f)
            MUL:    r = x * y;
            MULH:   begin p = {{64{x[63]}}, x} * {{64{y[63]}}, y}; r = p[127:64]; end
            MULHSU: begin p = {{64{x[63]}}, x} * {64'b0, y};       r = p[127:64]; end
            MULHU:  begin p = {64'b0, x} * {64'b0, y};             r = p[127:64]; end
            DIV: begin
                if (y == 0) r = '1;
                else if (x == 64'h8000_0000_0000_0000 && y == '1) r = x;
                else r = $signed(x) / $signed(y);
            end
            DIVU:   r = (y == 0) ? '1 : x / y;
            REM: begin
                if (y == 0) r = x;
                else if (x == 64'h8000_0000_0000_0000 && y == '1) r = '0;
                else r = $signed(x) % $signed(y);
            end
            default: r = (y == 0) ? x : x % y;
        endcase
        if (w) r = {{32{r[31]}}, r[31:0]};
        return r;
    endfunction

    // Unit latency in cycles from handshake to rvalid; div-by-zero/overflow finish early.
    function automatic int unsigned lat_md(input logic [2:0] f, input logic w,
                                           input logic [63:0] a, input logic [63:0] b);
        logic zero;
        logic ovf;
        if (!f[2]) return 3;
        if (w) begin
            zero = (b[31:0] == 32'h0);
            ovf  = !f[0] && (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF);
        end else begin
            zero = (b == 64'h0);
            ovf  = !f[0] && (a == 64'h8000_0000_0000_0000) && (b == '1);
        end
        return (zero || ovf) ? 2 : 6;
    endfunction

    // Behavioural mul/div unit: one op at a time, single-cycle rvalid pulse.
    logic          u_busy = 1'b0;
    int unsigned   u_cnt = 0;
    logic [XL-1:0] u_pend = '0;
    assign md_ready = !u_busy;

    always @(posedge clk) begin
        if (!rst) begin
            u_busy    <= 1'b0;
            u_cnt     <= 0;
            md_rvalid <= 1'b0;
            md_result <= '0;
        end else begin
            md_rvalid <= 1'b0;
            if (u_busy) begin
                if (u_cnt == 1) begin
                    md_rvalid <= 1'b1;
                    md_result <= u_pend;
                    u_busy    <= 1'b0;
                end else begin
                    u_cnt <= u_cnt - 1;
                end
            end else if (md_valid && md_ready) begin
                u_busy   <= 1'b1;
                u_cnt    <= lat_md(md_funct3, md_is_op32, md_op1, md_op2) - 1;
                u_pend   <= ref_md(md_funct3, md_is_op32, md_op1, md_op2);
                hs_count <= hs_count + 1;
            end
        end
    end

    // Writeback monitor and state observers, sampled on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (wb_valid) begin
                    n_beats++;
                    if (sb_q.size() == 0) begin
                        check_eq("wb_unexpected", 64'(wb_valid), 64'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check_eq("wb_data", wb_data, e.data);
                        check_eq("wb_rd", 64'(wb_rd), 64'(e.rd));
                    end
                end
                if (dut.state == DRAIN) drain_seen++;
                if (md_valid && dut.state != ISSUE) inv_viol++;
            end
        end
    end

    task automatic run_op(input logic [2:0] f, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input logic [RW-1:0] rd,
                          input logic [63:0] exp, input int unsigned exp_stall);
        exp_t e;
        int unsigned n;
        n = 0;
        ex_valid     = 1'b1;
        ex_is_muldiv = 1'b1;
        ex_funct3    = f;
        ex_is_op32   = w;
        ex_op1       = a;
        ex_op2       = b;
        ex_rd        = rd;
        e.rd   = rd;
        e.data = exp;
        sb_q.push_back(e);
        n_pushed++;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (stall) n++;
            else break;
        end
        check_eq("stall_cycles", 64'(n), 64'(exp_stall));
        @(posedge clk); #1;
        ex_valid     = 1'b0;
        ex_is_muldiv = 1'b0;
    endtask

    task automatic present(input logic [2:0] f, input logic [63:0] a,
                           input logic [63:0] b, input logic [RW-1:0] rd);
        ex_valid     = 1'b1;
        ex_is_muldiv = 1'b1;
        ex_funct3    = f;
        ex_is_op32   = 1'b0;
        ex_op1       = a;
        ex_op2       = b;
        ex_rd        = rd;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got still running expected finished");
        $fatal(1);
    end

    initial begin
        int unsigned hs0;
        int unsigned hit_stall;
        int unsigned hit_hs;
        logic [2:0]  rf;
        logic [63:0] ra;
        logic [63:0] rb;

`ifdef MULDIV_REUSE_EN
        hit_stall = 1;
        hit_hs    = 0;
`else
        hit_stall = 5;
        hit_hs    = 1;
`endif

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_stall", 64'(stall), 64'd0);
        check_eq("rst_md_valid", 64'(md_valid), 64'd0);
        check_eq("rst_wb_valid", 64'(wb_valid), 64'd0);
        check_eq("rst_wb_rd", 64'(wb_rd), 64'd0);
        check_eq("rst_wb_data", wb_data, 64'd0);
        check_eq("rst_md_op1", md_op1, 64'd0);
        next_cycle();
        rst = 1'b1;

        // Directed ops: stall cycles = 2 + unit latency
        run_op(MUL, 1'b0, 64'd3, -64'sd4, 5'd1, 64'hFFFF_FFFF_FFFF_FFF4, 5);
        run_op(DIV, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd2,
               64'hFFFF_FFFF_8000_0000, 4);
        run_op(DIVU, 1'b0, 64'h1234, 64'd0, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 4);
        run_op(REMU, 1'b0, 64'd7, 64'd0, 5'd4, 64'd7, 4);

        // Flush in WAIT: drain, new MUL stalls through the drain then completes
        present(DIV, 64'd100, 64'd7, 5'd5);
        next_cycle();
        next_cycle();
        flush = 1'b1;
        ex_valid = 1'b0;
        @(negedge clk);
        check_eq("flush_wait_stall", 64'(stall), 64'd0);
        next_cycle();
        flush = 1'b0;
        run_op(MUL, 1'b0, 64'd5, 64'd6, 5'd6, 64'd30, 10);
        check_eq("drain_seen", 64'(drain_seen != 0), 64'd1);

        // A drained result must not be reused
        run_op(DIV, 1'b0, 64'd100, 64'd7, 5'd7, 64'd14, 8);

        // Flush in the same cycle as rvalid
        present(MULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 5'd11);
        repeat (4) next_cycle();
        flush = 1'b1;
        ex_valid = 1'b0;
        @(negedge clk);
        check_eq("flush_rv_align", 64'(md_rvalid), 64'd1);
        next_cycle();
        flush = 1'b0;
        @(negedge clk);
        check_eq("flush_rv_no_wb", 64'(wb_valid), 64'd0);
        next_cycle();
        run_op(MULH, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 5'd11, 64'hFFFF_FFFF_FFFF_FFFF, 5);

        // Flush in ISSUE: no handshake
        hs0 = hs_count;
        present(DIVU, 64'd50, 64'd5, 5'd12);
        next_cycle();
        flush = 1'b1;
        ex_valid = 1'b0;
        @(negedge clk);
        check_eq("flush_issue_md_valid", 64'(md_valid), 64'd0);
        next_cycle();
        flush = 1'b0;
        repeat (8) next_cycle();
        check_eq("flush_issue_hs", 64'(hs_count), 64'(hs0));

        // Back-to-back MULHU with identical operands
        run_op(MULHU, 1'b0, '1, '1, 5'd8, 64'hFFFF_FFFF_FFFF_FFFE, 5);
        hs0 = hs_count;
        run_op(MULHU, 1'b0, '1, '1, 5'd9, 64'hFFFF_FFFF_FFFF_FFFE, hit_stall);
        check_eq("reuse_hs", 64'(hs_count - hs0), 64'(hit_hs));

        // Reset mid-operation: no writeback, registers cleared
        present(DIV, 64'd9, 64'd3, 5'd10);
        repeat (3) next_cycle();
        rst = 1'b0;
        ex_valid = 1'b0;
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_stall", 64'(stall), 64'd0);
        check_eq("midrst_wb_valid", 64'(wb_valid), 64'd0);
        check_eq("midrst_wb_data", wb_data, 64'd0);
        check_eq("midrst_wb_rd", 64'(wb_rd), 64'd0);
        repeat (10) next_cycle();
        run_op(MULHU, 1'b0, '1, '1, 5'd13, 64'hFFFF_FFFF_FFFF_FFFE, 5);

        // Mixed ops from the reference model
        run_op(REM, 1'b0, -64'sd7, 64'd2, 5'd14, 64'hFFFF_FFFF_FFFF_FFFF, 8);
        for (int k = 0; k < 4; k++) begin
            rf = 3'($urandom_range(0, 7));
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            run_op(rf, 1'b0, ra, rb, 5'(k + 16), ref_md(rf, 1'b0, ra, rb),
                   2 + lat_md(rf, 1'b0, ra, rb));
        end

        repeat (5) next_cycle();
        check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
        check_eq("wb_beats", 64'(n_beats), 64'(n_pushed));
        check_eq("md_valid_only_in_issue", 64'(inv_viol), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
